// File: rtl/div_pkg.sv
// Shared defaults for the pipelined restoring divider.
package div_pkg;

  localparam int unsigned DIV_N = 8;
  localparam int unsigned DIV_M = 4;

endpackage

// File: rtl/div_pipeline_stage.sv
// One registered step of the restoring divider: resolves quotient bit N-1-K and
// forwards the operands, partial quotient, running remainder and zero flag.
module div_pipeline_stage
  import div_pkg::*;
#(
  parameter int unsigned N = DIV_N,
  parameter int unsigned M = DIV_M,
  parameter int unsigned K = 0
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         valid_in,
  input  logic [M-1:0] divisor_in,
  input  logic [N-1:0] dividend_in,
  input  logic [N-1:0] quot_in,
  input  logic [M-1:0] rem_in,
  input  logic         zero_in,
  output logic         valid_out,
  output logic [M-1:0] divisor_out,
  output logic [N-1:0] dividend_out,
  output logic [N-1:0] quot_out,
  output logic [M-1:0] rem_out,
  output logic         zero_out
);

  localparam int unsigned Bit = N - 1 - K;

  logic [M:0]   partial;
  logic [M:0]   diff;
  logic         ge;
  logic         zero_d;
  logic [N-1:0] quot_d;
  logic [M-1:0] rem_d;

  // rem_in < divisor keeps partial < 2*divisor, so diff[M] is a clean borrow.
  always_comb begin
    partial = {rem_in, dividend_in[Bit]};
    diff    = partial - {1'b0, divisor_in};
    ge      = ~diff[M];
    zero_d  = zero_in | (divisor_in == '0);
    quot_d  = quot_in;
    rem_d   = '0;
    if (zero_d) begin
      quot_d[Bit] = 1'b1;
    end else if (ge) begin
      quot_d[Bit] = 1'b1;
      rem_d       = diff[M-1:0];
    end else begin
      quot_d[Bit] = 1'b0;
      rem_d       = partial[M-1:0];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_out    <= 1'b0;
      divisor_out  <= '0;
      dividend_out <= '0;
      quot_out     <= '0;
      rem_out      <= '0;
      zero_out     <= 1'b0;
    end else if (valid_in) begin
      valid_out    <= 1'b1;
      divisor_out  <= divisor_in;
      dividend_out <= dividend_in;
      quot_out     <= quot_d;
      rem_out      <= rem_d;
      zero_out     <= zero_d;
    end else begin
      // Bubbles carry all-zero data so idle outputs read as zero.
      valid_out    <= 1'b0;
      divisor_out  <= '0;
      dividend_out <= '0;
      quot_out     <= '0;
      rem_out      <= '0;
      zero_out     <= 1'b0;
    end
  end

endmodule

// File: rtl/div_pipeline.sv
// Fully pipelined unsigned restoring divider: N stages, one result per cycle,
// latency N. Divide by zero yields all-ones quotient, zero remainder, div_zero.
module div_pipeline
  import div_pkg::*;
#(
  parameter int unsigned N = DIV_N,
  parameter int unsigned M = DIV_M
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         data_rdy,
  input  logic [N-1:0] dividend,
  input  logic [M-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [M-1:0] remainder,
  output logic         div_zero,
  output logic         res_rdy
);

  logic         valid_c    [N+1];
  logic [M-1:0] divisor_c  [N+1];
  logic [N-1:0] dividend_c [N+1];
  logic [N-1:0] quot_c     [N+1];
  logic [M-1:0] rem_c      [N+1];
  logic         zero_c     [N+1];

  assign valid_c[0]    = data_rdy;
  assign divisor_c[0]  = divisor;
  assign dividend_c[0] = dividend;
  assign quot_c[0]     = '0;
  assign rem_c[0]      = '0;
  assign zero_c[0]     = 1'b0;

  for (genvar k = 0; k < N; k++) begin : g_stage
    div_pipeline_stage #(
      .N (N),
      .M (M),
      .K (k)
    ) u_stage (
      .clk          (clk),
      .rstn         (rstn),
      .valid_in     (valid_c[k]),
      .divisor_in   (divisor_c[k]),
      .dividend_in  (dividend_c[k]),
      .quot_in      (quot_c[k]),
      .rem_in       (rem_c[k]),
      .zero_in      (zero_c[k]),
      .valid_out    (valid_c[k+1]),
      .divisor_out  (divisor_c[k+1]),
      .dividend_out (dividend_c[k+1]),
      .quot_out     (quot_c[k+1]),
      .rem_out      (rem_c[k+1]),
      .zero_out     (zero_c[k+1])
    );
  end

  assign quotient  = quot_c[N];
  assign remainder = rem_c[N];
  assign div_zero  = zero_c[N];
  assign res_rdy   = valid_c[N];

  // Operands leaving the last stage have no consumer.
  logic unused_tail;
  assign unused_tail = ^{divisor_c[N], dividend_c[N]};

endmodule

// File: tb/tb_div_pipeline.sv
// Directed and random checks of div_pipeline (N=8, M=4) against a latency-N
// expected-result shift register filled with hand-computed or reference values.
module tb_div_pipeline;

  localparam int unsigned N = 8;
  localparam int unsigned M = 4;

  logic         clk;
  logic         rstn;
  logic         data_rdy;
  logic [N-1:0] dividend;
  logic [M-1:0] divisor;
  logic [N-1:0] quotient;
  logic [M-1:0] remainder;
  logic         div_zero;
  logic         res_rdy;

  int unsigned n_checks;
  int unsigned n_pass;

  logic         sr_v [N];
  logic [N-1:0] sr_q [N];
  logic [M-1:0] sr_r [N];
  logic         sr_z [N];

  div_pipeline #(
    .N (N),
    .M (M)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .data_rdy  (data_rdy),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .res_rdy   (res_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic flush_model();
    for (int i = 0; i < N; i++) begin
      sr_v[i] = 1'b0;
      sr_q[i] = '0;
      sr_r[i] = '0;
      sr_z[i] = 1'b0;
    end
  endtask

  // One cycle: check the result due now, then issue (or idle) for this cycle.
  task automatic step(input logic v, input logic [N-1:0] a, input logic [M-1:0] b,
                      input logic [N-1:0] eq, input logic [M-1:0] er, input logic ez);
    @(negedge clk);
    check("res_rdy", 32'(res_rdy), 32'(sr_v[N-1]));
    check("quotient", 32'(quotient), 32'(sr_q[N-1]));
    check("remainder", 32'(remainder), 32'(sr_r[N-1]));
    check("div_zero", 32'(div_zero), 32'(sr_z[N-1]));
    for (int i = N - 1; i > 0; i--) begin
      sr_v[i] = sr_v[i-1];
      sr_q[i] = sr_q[i-1];
      sr_r[i] = sr_r[i-1];
      sr_z[i] = sr_z[i-1];
    end
    sr_v[0]  = v;
    sr_q[0]  = v ? eq : '0;
    sr_r[0]  = v ? er : '0;
    sr_z[0]  = v ? ez : 1'b0;
    data_rdy = v;
    dividend = v ? a : '0;
    divisor  = v ? b : '0;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, '0, '0, '0, '0, 1'b0);
  endtask

  initial begin
    logic [N-1:0] a;
    logic [M-1:0] b;
    logic         v;
    n_checks = 0;
    n_pass   = 0;
    flush_model();
    rstn     = 1'b0;
    data_rdy = 1'b0;
    dividend = '0;
    divisor  = '0;
    #12;
    check("reset res_rdy", 32'(res_rdy), 32'd0);
    check("reset quotient", 32'(quotient), 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    // Single operation and extremes.
    step(1'b1, 8'd100, 4'd7, 8'd14, 4'd2, 1'b0);
    idle(N + 1);
    step(1'b1, 8'd255, 4'd15, 8'd17, 4'd0, 1'b0);
    step(1'b1, 8'd5, 4'd9, 8'd0, 4'd5, 1'b0);
    step(1'b1, 8'd0, 4'd3, 8'd0, 4'd0, 1'b0);
    step(1'b1, 8'd13, 4'd0, 8'd255, 4'd0, 1'b1);
    step(1'b1, 8'd200, 4'd13, 8'd15, 4'd5, 1'b0);
    step(1'b1, 8'd255, 4'd1, 8'd255, 4'd0, 1'b0);
    step(1'b1, 8'd0, 4'd0, 8'd255, 4'd0, 1'b1);
    idle(N);

    // Stream with one bubble.
    step(1'b1, 8'd100, 4'd7, 8'd14, 4'd2, 1'b0);
    step(1'b1, 8'd255, 4'd15, 8'd17, 4'd0, 1'b0);
    idle(1);
    step(1'b1, 8'd200, 4'd13, 8'd15, 4'd5, 1'b0);
    idle(N);

    // Reset while the pipe is full and a result sits on the outputs.
    for (int i = 0; i < N + 1; i++) step(1'b1, 8'd100, 4'd7, 8'd14, 4'd2, 1'b0);
    @(negedge clk);
    check("pre-reset res_rdy", 32'(res_rdy), 32'd1);
    data_rdy = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    check("async res_rdy", 32'(res_rdy), 32'd0);
    check("async quotient", 32'(quotient), 32'd0);
    check("async remainder", 32'(remainder), 32'd0);
    flush_model();
    @(negedge clk);
    rstn = 1'b1;
    idle(20);
    step(1'b1, 8'd100, 4'd7, 8'd14, 4'd2, 1'b0);
    idle(N);

    // Random operands with random bubbles; divisor 0 occurs naturally.
    for (int i = 0; i < 10000; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 4'($urandom_range(0, 15));
      v = ($urandom_range(0, 7) != 0);
      if (b == '0) step(v, a, b, 8'hff, 4'd0, 1'b1);
      else step(v, a, b, a / 8'(b), 4'(a % 8'(b)), 1'b0);
    end
    idle(N + 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
